// File: rtl/tick_scheduler_if.sv
// Configuration and event-delivery bus of tick_scheduler.
// master = scheduler side, slave = client (configuring agent and event consumer).
interface tick_scheduler_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned PW   = 8
);
    localparam int unsigned CW = $clog2(N_CH);

    logic            cfg_we;
    logic [CW-1:0]   cfg_ch;
    logic [PW-1:0]   cfg_period;
    logic            tick;
    logic            evt_valid;
    logic [CW-1:0]   evt_ch;
    logic            evt_ready;
    logic [N_CH-1:0] overrun;

    modport master (
        input  cfg_we, cfg_ch, cfg_period, evt_ready,
        output tick, evt_valid, evt_ch, overrun
    );

    modport slave (
        output cfg_we, cfg_ch, cfg_period, evt_ready,
        input  tick, evt_valid, evt_ch, overrun
    );
endinterface

// File: rtl/tick_scheduler.sv
// Shared slow time base: prescaled tick, N_CH periodic channels, round-robin event delivery.
// Define TICK_SCHED_OVERRUN_EN to build the sticky per-channel overrun flags.
module tick_scheduler #(
    parameter int unsigned F_CLK  = 50000000,
    parameter int unsigned F_TICK = 1000,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned PW     = 8
) (
    input logic              clk,
    input logic              rst,
    tick_scheduler_if.master bus
);
    localparam int unsigned N  = F_CLK / F_TICK;
    localparam int unsigned CW = $clog2(N_CH);
    localparam int unsigned DW = $clog2(N);
    localparam logic [DW-1:0] PRESC_MAX = DW'(N - 1);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   presc;
    logic            tick_q;
    logic [PW-1:0]   period [N_CH];
    logic [PW-1:0]   count  [N_CH];
    logic [N_CH-1:0] pending, pending_nx;
    logic [N_CH-1:0] wr_sel, hs_sel, latched, expire;
    logic            hs;
    logic            grant_vld;
    logic [CW-1:0]   grant;
    logic [CW-1:0]   ptr, ptr_nx;
    logic [CW-1:0]   evt_ch_q, evt_ch_nx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc  <= PRESC_MAX;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (presc == '0);
            presc  <= (presc == '0) ? PRESC_MAX : presc - 1'b1;
        end
    end

    // A write on a channel masks its expiry that cycle; the written value wins.
    always_comb begin
        wr_sel  = '0;
        hs_sel  = '0;
        latched = '0;
        expire  = '0;
        hs      = (state == PRESENT) && bus.evt_ready;
        for (int unsigned i = 0; i < N_CH; i++) begin
            wr_sel[i]  = bus.cfg_we && (32'(bus.cfg_ch) == i);
            latched[i] = (state == PRESENT) && (32'(evt_ch_q) == i);
            hs_sel[i]  = hs && latched[i];
            expire[i]  = tick_q && (period[i] != '0) && (count[i] == PW'(1)) && !wr_sel[i];
        end
    end

    always_comb begin
        pending_nx = pending;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (hs_sel[i])
                pending_nx[i] = 1'b0;
            if (wr_sel[i] && !latched[i])
                pending_nx[i] = 1'b0;
            if (expire[i])
                pending_nx[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                period[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            pending <= pending_nx;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (wr_sel[i]) begin
                    period[i] <= bus.cfg_period;
                    count[i]  <= bus.cfg_period;
                end else if (tick_q && (period[i] != '0)) begin
                    count[i] <= (count[i] == PW'(1)) ? period[i] : count[i] - 1'b1;
                end
            end
        end
    end

    // First pending channel at or after ptr; a channel being rewritten is skipped.
    always_comb begin : arb_pick
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant     = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (32'(ptr) + k) % N_CH;
            if (!grant_vld && pending[CW'(idx)] && !wr_sel[CW'(idx)]) begin
                grant_vld = 1'b1;
                grant     = CW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            evt_ch_q <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            evt_ch_q <= evt_ch_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        evt_ch_nx = evt_ch_q;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    evt_ch_nx = grant;
                    state_nx  = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.evt_ready) begin
                    ptr_nx   = (32'(evt_ch_q) == N_CH - 1) ? '0 : evt_ch_q + 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef TICK_SCHED_OVERRUN_EN
    logic [N_CH-1:0] overrun_q;

    always_ff @(posedge clk) begin
        if (!rst)
            overrun_q <= '0;
        else
            overrun_q <= (overrun_q & ~wr_sel) | (expire & pending & ~hs_sel);
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = '0;
`endif

    assign bus.tick      = tick_q;
    assign bus.evt_valid = (state == PRESENT);
    assign bus.evt_ch    = evt_ch_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a cycle-level reference model and a per-cycle compare.
module tb_tick_scheduler;
    localparam int F_CLK  = 100;
    localparam int F_TICK = 10;
    localparam int N_CH   = 4;
    localparam int PW     = 8;
    localparam int CW     = 2;
    localparam int N      = F_CLK / F_TICK;
`ifdef TICK_SCHED_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    tick_scheduler_if #(.N_CH(N_CH), .PW(PW)) bus ();

    tick_scheduler #(.F_CLK(F_CLK), .F_TICK(F_TICK), .N_CH(N_CH), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: ticks counted since reset, ticks-remaining per channel,
    // pending/overrun flags and a presenting flag with round-robin pointer.
    int m_cyc;
    bit m_tick;
    bit m_valid;
    int m_ch;
    int m_ptr;
    int m_per  [N_CH];
    int m_rem  [N_CH];
    bit m_pend [N_CH];
    bit m_ovr  [N_CH];

    task automatic model_reset();
        m_cyc = 0; m_tick = 0; m_valid = 0; m_ch = 0; m_ptr = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_per[c] = 0; m_rem[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        end
    endtask

    task automatic model_step();
        bit hs;
        bit wr   [N_CH];
        bit old  [N_CH];
        bit fire;
        bit mine;
        int grant;
        hs = m_valid && (bus.evt_ready === 1'b1);
        for (int c = 0; c < N_CH; c++) begin
            wr[c]  = (bus.cfg_we === 1'b1) && (int'(bus.cfg_ch) == c);
            old[c] = m_pend[c];
            fire   = 0;
            mine   = m_valid && (m_ch == c);
            if (wr[c]) begin
                m_per[c] = int'(bus.cfg_period);
                m_rem[c] = m_per[c];
            end else if (m_tick && m_per[c] != 0) begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    fire = 1;
                    m_rem[c] = m_per[c];
                end
            end
            if (hs && mine) m_pend[c] = 0;
            if (wr[c] && !mine) m_pend[c] = 0;
            if (wr[c]) m_ovr[c] = 0;
            if (fire) begin
                if (old[c] && !(hs && mine)) m_ovr[c] = OVR_EN;
                m_pend[c] = 1;
            end
        end
        if (m_valid) begin
            if (hs) begin
                m_valid = 0;
                m_ptr = (m_ch + 1) % N_CH;
            end
        end else begin
            grant = -1;
            for (int k = 0; k < N_CH; k++)
                if (grant < 0 && old[(m_ptr + k) % N_CH] && !wr[(m_ptr + k) % N_CH])
                    grant = (m_ptr + k) % N_CH;
            if (grant >= 0) begin
                m_valid = 1;
                m_ch = grant;
            end
        end
        m_cyc++;
        m_tick = (m_cyc % N == 0);
    endtask

    always @(posedge clk) begin
        if (rst !== 1'b1) model_reset();
        else model_step();
    end

    // Per-cycle compare of all outputs: {tick, evt_valid, evt_ch, overrun}.
    always @(negedge clk) begin
        logic [31:0] act, exp;
        logic [N_CH-1:0] e_ovr;
        for (int c = 0; c < N_CH; c++) e_ovr[c] = m_ovr[c];
        act = {24'b0, bus.tick, bus.evt_valid, bus.evt_ch, bus.overrun};
        exp = {24'b0, m_tick, m_valid, CW'(m_ch), e_ovr};
        check("cycle_outputs", act, exp);
    end

    int tb_cyc = 0;
    int tick_cnt = 0;
    int last_tick_cyc = 0;

    always @(posedge clk) begin
        tb_cyc++;
        #1;
        if (bus.tick === 1'b1) begin
            tick_cnt++;
            last_tick_cyc = tb_cyc;
        end
    end

    task automatic wr_ch(input int ch, input int p);
        bus.cfg_we = 1'b1;
        bus.cfg_ch = CW'(ch);
        bus.cfg_period = PW'(p);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.evt_valid === 1'b1) ok = 1;
        end
    endtask

    task automatic wait_tick(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) ok = 1;
        end
    endtask

    initial begin
        bit ok;
        int tk0;
        int cnt;
        int rr_exp [6];
        rr_exp = '{0, 2, 3, 0, 2, 3};
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_period = '0;
        bus.evt_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_evt_valid", 32'(bus.evt_valid), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_evt_ch", 32'(bus.evt_ch), 0);
        check("rst_overrun", 32'(bus.overrun), 0);

        // Prescaler: tick on the 10th, 20th, 30th edge after release
        rst = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 9 || k == 11 || k == 19 || k == 21)
                check("presc_tick_low", 32'(bus.tick), 0);
            if (k == 10 || k == 20 || k == 30)
                check("presc_tick_high", 32'(bus.tick), 1);
        end

        // Single channel, period 3, consumer always ready
        bus.evt_ready = 1'b1;
        tk0 = tick_cnt;
        wr_ch(1, 3);
        wait_valid(60, ok);
        check("single_first_seen", 32'(ok), 1);
        check("single_ch", 32'(bus.evt_ch), 1);
        check("single_tick_index", 32'(tick_cnt - tk0), 3);
        check("single_latency", 32'(tb_cyc - last_tick_cyc), 2);
        @(negedge clk);
        check("single_width", 32'(bus.evt_valid), 0);
        wait_valid(60, ok);
        check("single_second_seen", 32'(ok), 1);
        check("single_second_index", 32'(tick_cnt - tk0), 6);

        // Round-robin among channels 0, 2, 3 at period 1
        do_reset();
        wait_tick(20, ok);
        check("rr_tick_seen", 32'(ok), 1);
        wr_ch(0, 1);
        wr_ch(2, 1);
        wr_ch(3, 1);
        for (int e = 0; e < 6; e++) begin
            wait_valid(30, ok);
            check("rr_seen", 32'(ok), 1);
            check("rr_order", 32'(bus.evt_ch), 32'(rr_exp[e]));
        end
        @(negedge clk);
        bus.evt_ready = 1'b0;
        wait_valid(30, ok);
        check("stall_seen", 32'(ok), 1);
        check("stall_ch", 32'(bus.evt_ch), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid_held", 32'(bus.evt_valid), 1);
            check("stall_ch_stable", 32'(bus.evt_ch), 0);
        end
        bus.evt_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Overrun on channel 2 with the consumer stalled for 3 ticks
        do_reset();
        bus.evt_ready = 1'b0;
        wr_ch(2, 1);
        for (int t = 0; t < 3; t++) begin
            wait_tick(20, ok);
            check("ovr_tick_seen", 32'(ok), 1);
        end
        check("ovr_flag", 32'(bus.overrun), OVR_EN ? 32'h4 : 32'h0);
        check("ovr_valid", 32'(bus.evt_valid), 1);
        check("ovr_ch", 32'(bus.evt_ch), 2);
        repeat (2) @(negedge clk);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("ovr_single_event", 32'(bus.evt_valid), 0);
            if (i < 5) @(negedge clk);
        end
        check("ovr_flag_sticky", 32'(bus.overrun), OVR_EN ? 32'h4 : 32'h0);
        wr_ch(2, 0);
        check("ovr_cleared_by_write", 32'(bus.overrun), 0);
        repeat (15) @(negedge clk);

        // Disabling the channel whose event is being presented
        do_reset();
        bus.evt_ready = 1'b0;
        wr_ch(1, 2);
        wait_valid(60, ok);
        check("wp_seen", 32'(ok), 1);
        check("wp_ch", 32'(bus.evt_ch), 1);
        wr_ch(1, 0);
        for (int i = 0; i < 3; i++) begin
            check("wp_valid_held", 32'(bus.evt_valid), 1);
            @(negedge clk);
        end
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        check("wp_handshake_done", 32'(bus.evt_valid), 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.evt_valid === 1'b1) cnt++;
        end
        check("wp_no_more_events", 32'(cnt), 0);

        // Reset asserted during a handshake
        wr_ch(3, 1);
        wait_valid(30, ok);
        check("rh_seen", 32'(ok), 1);
        bus.evt_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rh_valid_dropped", 32'(bus.evt_valid), 0);
        check("rh_overrun_clear", 32'(bus.overrun), 0);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.evt_valid === 1'b1) cnt++;
        end
        check("rh_quiet_after_reset", 32'(cnt), 0);
        wr_ch(3, 1);
        wait_valid(30, ok);
        check("rh_resumes", 32'(ok), 1);
        check("rh_resume_ch", 32'(bus.evt_ch), 3);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel periodic event scheduler for the console's slow-time domain (game timers, animation steps, sound sequencer steps). It derives one base tick from the system clock with an internal prescaler and runs N_CH independently programmable period counters off that tick. Expired channels are queued as pending events and delivered one at a time over a valid/ready handshake, chosen by a round-robin arbiter. It replaces per-consumer slow-clock dividers with one shared, configurable time base.

## Interface
- F_CLK, 50000000: system clock frequency in Hz.
- F_TICK, 1000: base tick rate in Hz. N = F_CLK / F_TICK must be an integer ≥ 2.
- N_CH, 4: number of channels, 2..16.
- PW, 8: period register width in ticks.

- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- cfg_we  in  1  one-cycle channel configuration write strobe.
- cfg_ch  in  $clog2(N_CH)  channel addressed by cfg_we. Values ≥ N_CH are ignored.
- cfg_period  in  PW  period in ticks. 0 disables the channel.
- tick  out  1  one-cycle base tick pulse.
- evt_valid  out  1  event available.
- evt_ch  out  $clog2(N_CH)  channel of the presented event.
- evt_ready  in  1  consumer accepts the event.
- overrun  out  N_CH  sticky per-channel overrun flags.

## Operation
- Prescaler: a down-counter is reloaded with N-1 and decrements every cycle. tick is registered and goes high for exactly one cycle every N cycles. The first tick occurs N cycles after rst deasserts.
- Per-channel state: period P, counter C, pending bit.
- Channel write (cfg_we):
  - Sets P = cfg_period and C = cfg_period.
  - Clears overrun for that channel.
  - Clears pending, unless that channel is the event currently latched on evt_ch with evt_valid high. A latched event always completes normally.
- Channel countdown: on each tick, every channel with P ≠ 0 decrements C. When C is 1 before the decrement, the channel expires: C reloads to P and pending is set. A channel with P = 1 therefore expires on every tick.
- Overrun: an expiry while pending is already set, and not being cleared that cycle, sets overrun[ch]. Pending stays 1; events are not counted.
- Simultaneous expiry and handshake on the same channel: pending ends at 1, overrun is not set.
- Simultaneous cfg_we and tick on the same channel: the write wins. C = cfg_period, and no expiry is taken that cycle.
- Arbiter FSM:
  - IDLE: if any pending bit is set, grant the first pending channel at or after pointer ptr (wrapping). Latch evt_ch, go to PRESENT.
  - PRESENT: evt_valid = 1, and evt_ch is held stable. On evt_valid && evt_ready, clear that channel's pending, set ptr = evt_ch + 1 (mod N_CH), go to IDLE.
- evt_valid is low for at least one cycle between consecutive events.
- Reset values:
  - tick = 0, evt_valid = 0, evt_ch = 0, overrun = 0.
  - All P = 0, C = 0, pending = 0, ptr = 0, FSM = IDLE.
  - Prescaler = N-1.
- Reset asserted mid-operation drops evt_valid on the next edge. A handshake in progress is discarded.

## Timing
- tick high in cycle t causes expiry; pending is visible at t+1. evt_valid rises at t+2 if the FSM was IDLE.
- Handshake in cycle h: evt_valid is low at h+1. The next event can be valid at h+2.
- cfg_we in cycle w: the channel expires on the P-th tick strictly after w.
- A cfg_we to a disabled channel takes effect the next cycle. No event is generated from the write itself.
- Tick-to-event worst case with all channels pending: 2 + 2·(N_CH-1) cycles plus consumer stall.

## Configuration
- TICK_SCHED_OVERRUN_EN defined: the overrun sticky flags are implemented as specified.
- TICK_SCHED_OVERRUN_EN undefined: no overrun registers exist and overrun is tied to 0. Pending-merge behaviour is unchanged.

## Test plan
- Prescaler: F_CLK=100, F_TICK=10, release rst at cycle 0 → tick high at cycles 10, 20, 30, each for exactly 1 cycle.
- Single channel: write ch1 period 3, evt_ready tied 1 → evt_valid with evt_ch=1 two cycles after every 3rd tick, 1 cycle wide each.
- Round-robin: ch0, ch2 and ch3 all period 1, evt_ready high → order 0, 2, 3, 0, 2, 3. evt_ch is stable while evt_ready is held low for 5 cycles.
- Overrun: ch2 period 1, evt_ready low for 3 ticks → overrun[2]=1 and one pending event only. A later cfg write to ch2 clears overrun[2].
- Write during presentation: ch1 presented, evt_ready low, cfg_we ch1 period 0 → evt_valid stays 1 until the handshake, then there are no further ch1 events.
- Reset mid-handshake: assert rst while evt_valid=1 → next cycle evt_valid=0, overrun=0, and no events occur until new cfg writes.
